// File: rtl/and2_exor2_nand2.sv
// rtl/and2_exor2_nand2.sv - registered bitwise AND/XOR/NAND unit behind a one-entry valid/ready stage; optional parity outputs under AND2_EXOR2_NAND2_PARITY_EN
module and2_exor2_nand2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] exor_out,
    output logic [WIDTH-1:0] nand_out
`ifdef AND2_EXOR2_NAND2_PARITY_EN
    ,
    output logic             and_par,
    output logic             exor_par,
    output logic             nand_par
`endif
);

    logic             valid_q, valid_d;
    logic             accept;
    logic [WIDTH-1:0] and_q, and_d;
    logic [WIDTH-1:0] exor_q, exor_d;
    logic [WIDTH-1:0] nand_q, nand_d;

    // Ready is purely combinational so a full register can drain and refill in one cycle.
    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        and_d   = a & b;
        exor_d  = a ^ b;
        nand_d  = ~(a & b);
        valid_d = accept | (valid_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            and_q   <= '0;
            exor_q  <= '0;
            nand_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                and_q  <= and_d;
                exor_q <= exor_d;
                nand_q <= nand_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign and_out   = and_q;
    assign exor_out  = exor_q;
    assign nand_out  = nand_q;

`ifdef AND2_EXOR2_NAND2_PARITY_EN
    logic and_par_q, exor_par_q, nand_par_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            and_par_q  <= 1'b0;
            exor_par_q <= 1'b0;
            nand_par_q <= 1'b0;
        end else if (accept) begin
            and_par_q  <= ^and_d;
            exor_par_q <= ^exor_d;
            nand_par_q <= ^nand_d;
        end
    end

    assign and_par  = and_par_q;
    assign exor_par = exor_par_q;
    assign nand_par = nand_par_q;
`endif

endmodule

// File: tb/tb_and2_exor2_nand2.sv
// tb/tb_and2_exor2_nand2.sv - bench for and2_exor2_nand2 at WIDTH=1 and WIDTH=8
module tb_and2_exor2_nand2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // WIDTH=1 instance
    logic       v1, rdy1, ov1, or1;
    logic [0:0] a1, b1, and1, ex1, na1;
    // WIDTH=8 instance
    logic       v8, rdy8, ov8, or8;
    logic [7:0] a8, b8, and8, ex8, na8;
`ifdef AND2_EXOR2_NAND2_PARITY_EN
    logic ap1, ep1, np1, ap8, ep8, np8;
`endif

    and2_exor2_nand2 #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1),
        .and_out(and1), .exor_out(ex1), .nand_out(na1)
`ifdef AND2_EXOR2_NAND2_PARITY_EN
        , .and_par(ap1), .exor_par(ep1), .nand_par(np1)
`endif
    );

    and2_exor2_nand2 #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
        .and_out(and8), .exor_out(ex8), .nand_out(na8)
`ifdef AND2_EXOR2_NAND2_PARITY_EN
        , .and_par(ap8), .exor_par(ep8), .nand_par(np8)
`endif
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] ex;
        logic [7:0] na;
    } res_t;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; or1 = 1'b0;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; or8 = 1'b0;
        tick();
        tick();
        n_vec++;
        if (ov8 !== 1'b0 || and8 !== 8'h00 || ex8 !== 8'h00 || na8 !== 8'h00 || rdy8 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_w8: got v=%b and=%h ex=%h na=%h rdy=%b, want v=0 and=00 ex=00 na=00 rdy=1",
                     ov8, and8, ex8, na8, rdy8);
        end
        n_vec++;
        if (ov1 !== 1'b0 || and1 !== 1'b0 || ex1 !== 1'b0 || na1 !== 1'b0 || rdy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_w1: got v=%b and=%b ex=%b na=%b rdy=%b, want all 0, rdy=1",
                     ov1, and1, ex1, na1, rdy1);
        end
        rst_n = 1'b1;
        v1 = 1'b0; v8 = 1'b0;
        tick();
    endtask

    task automatic test_truth_table();
        logic [3:0] ta, tb_, te_and, te_ex, te_na;
        ta     = 4'b1010;   // pairs (0,0),(1,0),(0,1),(1,1) indexed 0..3
        tb_    = 4'b1100;
        te_and = 4'b1000;
        te_ex  = 4'b0110;
        te_na  = 4'b0111;
        or1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1; a1 = ta[i]; b1 = tb_[i];
            tick();
            n_vec++;
            if (ov1 !== 1'b1 || and1 !== te_and[i] || ex1 !== te_ex[i] || na1 !== te_na[i]) begin
                n_bad++;
                $display("FAIL truth_%0d: got v=%b and=%b ex=%b na=%b, want v=1 and=%b ex=%b na=%b",
                         i, ov1, and1, ex1, na1, te_and[i], te_ex[i], te_na[i]);
            end
        end
        v1 = 1'b0;
        tick();
        n_vec++;
        if (ov1 !== 1'b0) begin
            n_bad++;
            $display("FAIL truth_drain: got out_valid=%b, want 0", ov1);
        end
    endtask

    task automatic test_backpressure();
        v8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; or8 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); v8 = 1'b1;
            #1;
            n_vec++;
            if (ov8 !== 1'b1 || and8 !== 8'h30 || ex8 !== 8'hCC || na8 !== 8'hCF || rdy8 !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure_%0d: got v=%b and=%h ex=%h na=%h rdy=%b, want v=1 and=30 ex=CC na=CF rdy=0",
                         i, ov8, and8, ex8, na8, rdy8);
            end
`ifdef AND2_EXOR2_NAND2_PARITY_EN
            n_vec++;
            if (ap8 !== 1'b0 || ep8 !== 1'b0 || np8 !== 1'b0) begin
                n_bad++;
                $display("FAIL parity_f0_3c: got %b%b%b, want 000", ap8, ep8, np8);
            end
`endif
            @(posedge clk); #1;
        end
        v8 = 1'b0; or8 = 1'b1;
        tick();
        n_vec++;
        if (ov8 !== 1'b0 || and8 !== 8'h30) begin
            n_bad++;
            $display("FAIL backpressure_drain: got v=%b and=%h, want v=0 and=30", ov8, and8);
        end
    endtask

    task automatic test_back_to_back();
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F; or8 = 1'b0;
        tick();
        n_vec++;
        if (ov8 !== 1'b1 || and8 !== 8'h0F || ex8 !== 8'hF0 || na8 !== 8'hF0) begin
            n_bad++;
            $display("FAIL b2b_held: got v=%b and=%h ex=%h na=%h, want v=1 and=0F ex=F0 na=F0",
                     ov8, and8, ex8, na8);
        end
        a8 = 8'hAA; b8 = 8'h55; or8 = 1'b1;
        #1;
        n_vec++;
        if (rdy8 !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: got in_ready=%b, want 1", rdy8);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ov8 !== 1'b1 || and8 !== 8'h00 || ex8 !== 8'hFF || na8 !== 8'hFF) begin
            n_bad++;
            $display("FAIL b2b_new: got v=%b and=%h ex=%h na=%h, want v=1 and=00 ex=FF na=FF",
                     ov8, and8, ex8, na8);
        end
        v8 = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        v8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; or8 = 1'b0;
        tick();
        rst_n = 1'b0; v8 = 1'b1; a8 = 8'h77; b8 = 8'h11; or8 = 1'b1;
        tick();
        rst_n = 1'b1; v8 = 1'b0; or8 = 1'b0;
        #1;
        n_vec++;
        if (ov8 !== 1'b0 || and8 !== 8'h00 || ex8 !== 8'h00 || na8 !== 8'h00 || rdy8 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_midop: got v=%b and=%h ex=%h na=%h rdy=%b, want v=0 all 00 rdy=1",
                     ov8, and8, ex8, na8, rdy8);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ov8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_capture: got out_valid=%b, want 0", ov8);
        end
    endtask

    task automatic test_random_stream();
        res_t q[$];
        res_t r;
        int   pushed = 0, popped = 0;
        logic exp_rdy;
        for (int i = 0; i < 1000; i++) begin
            v8  = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            or8 = 1'($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() == 0) || or8;
            n_vec++;
            if (ov8 !== (q.size() != 0) || rdy8 !== exp_rdy) begin
                n_bad++;
                $display("FAIL rand_hs_%0d: got v=%b rdy=%b, want v=%b rdy=%b",
                         i, ov8, rdy8, q.size() != 0, exp_rdy);
            end
            if (q.size() != 0) begin
                n_vec++;
                if (and8 !== q[0].an || ex8 !== q[0].ex || na8 !== q[0].na) begin
                    n_bad++;
                    $display("FAIL rand_data_%0d: got and=%h ex=%h na=%h, want and=%h ex=%h na=%h",
                             i, and8, ex8, na8, q[0].an, q[0].ex, q[0].na);
                end
`ifdef AND2_EXOR2_NAND2_PARITY_EN
                n_vec++;
                if (ap8 !== ^q[0].an || ep8 !== ^q[0].ex || np8 !== ^q[0].na) begin
                    n_bad++;
                    $display("FAIL rand_par_%0d: got %b%b%b, want %b%b%b",
                             i, ap8, ep8, np8, ^q[0].an, ^q[0].ex, ^q[0].na);
                end
`endif
                if (or8) begin
                    void'(q.pop_front());
                    popped++;
                end
            end
            if (v8 && exp_rdy) begin
                r.an = a8 & b8;
                r.ex = a8 ^ b8;
                r.na = ~(a8 & b8);
                q.push_back(r);
                pushed++;
            end
            @(posedge clk); #1;
        end
        v8 = 1'b0; or8 = 1'b1;
        #1;
        if (q.size() != 0) begin
            n_vec++;
            if (ov8 !== 1'b1 || and8 !== q[0].an) begin
                n_bad++;
                $display("FAIL rand_tail: got v=%b and=%h, want v=1 and=%h", ov8, and8, q[0].an);
            end
            void'(q.pop_front());
            popped++;
        end
        @(posedge clk); #1;
        n_vec++;
        if (ov8 !== 1'b0 || pushed != popped) begin
            n_bad++;
            $display("FAIL rand_count: got v=%b pushed=%0d popped=%0d, want v=0 and equal counts",
                     ov8, pushed, popped);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
